// File: rtl/packet_receiver.sv
// packet_receiver: serial receive side of the laser TCP link.
// Hunts for SYNC_WORD, then shifts in one 288-bit packet (9 x 32-bit words)
// MSB first. While shifting, it keeps a running ones'-complement sum of the
// 16-bit halfwords. A good packet is presented on the outputs with a
// one-cycle readyout pulse.
// Optional build macro PORT_FILTER_EN: when defined, a good packet whose
// dstport differs from LOCAL_PORT is dropped silently.
module packet_receiver #(
  parameter logic [31:0] SYNC_WORD  = 32'hA5A5_F00D,
  parameter int unsigned TIMEOUT    = 65000,
  parameter logic [15:0] LOCAL_PORT = 16'd80
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic         readyout,
  output logic [31:0]  SEQout,
  output logic [31:0]  ACKout,
  output logic [8:0]   flagsout,
  output logic [15:0]  windowout,
  output logic [127:0] message,
  output logic         busy,
  output logic [7:0]   crc_errors,
  output logic [7:0]   timeouts
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {HUNT, RECV, CHECK} state_t;

  state_t          state;
  logic [31:0]     sync_sh;
  logic [287:0]    pkt;
  logic [8:0]      bit_cnt;
  logic [15:0]     acc;
  logic [TO_W-1:0] to_cnt;
  logic            deliver;

  logic [31:0] sync_next;
  logic [15:0] halfword;
  logic [16:0] acc_sum;
  logic [15:0] acc_fold;
  logic        sum_ok;
  logic        port_ok;

  // Candidate sync window, and the halfword completed by the bit being
  // sampled now.
  assign sync_next = {sync_sh[30:0], bit_in};
  assign halfword  = {pkt[14:0], bit_in};

  // Ones'-complement add with the carry folded straight back in. The folded
  // result never overflows again: the maximum is 0xFFFE + 1.
  assign acc_sum  = {1'b0, acc} + {1'b0, halfword};
  assign acc_fold = acc_sum[15:0] + {15'd0, acc_sum[16]};
  assign sum_ok   = (acc == 16'hFFFF);

`ifdef PORT_FILTER_EN
  assign port_ok = (pkt[271:256] == LOCAL_PORT);
`else
  assign port_ok = 1'b1;
`endif

  // pkt[287] is shifted out and never read. LOCAL_PORT matters only in the
  // filtered build.
  logic unused;
  assign unused = ^{pkt[287], LOCAL_PORT};

  assign busy = (state != HUNT);

  // Packet shift register: it is loaded only in RECV.
  // NOTE: this register is deliberately not reset. bit_cnt decides when its
  // contents are meaningful, so stale data after a reset is harmless.
  always_ff @(posedge clk) begin
    if (state == RECV && bit_valid) pkt <= {pkt[286:0], bit_in};
  end

  // Receiver FSM. The outputs and counters are registered here.
  // NOTE: all state here uses non-blocking assignments, so every branch sees
  // the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      sync_sh    <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
      to_cnt     <= '0;
      deliver    <= 1'b0;
      readyout   <= 1'b0;
      SEQout     <= '0;
      ACKout     <= '0;
      flagsout   <= '0;
      windowout  <= '0;
      message    <= '0;
      crc_errors <= '0;
      timeouts   <= '0;
    end else begin
      // deliver is set in CHECK, so the outputs and readyout update one
      // edge later.
      readyout <= deliver;
      deliver  <= 1'b0;
      if (deliver) begin
        SEQout    <= pkt[255:224];
        ACKout    <= pkt[223:192];
        flagsout  <= pkt[184:176];
        windowout <= pkt[175:160];
        message   <= pkt[127:0];
      end

      case (state)
        HUNT: begin
          if (bit_valid) begin
            if (sync_next == SYNC_WORD) begin
              state   <= RECV;
              sync_sh <= '0;
              bit_cnt <= '0;
              acc     <= '0;
              to_cnt  <= '0;
            end else begin
              sync_sh <= sync_next;
            end
          end
        end

        RECV: begin
          if (bit_valid) begin
            bit_cnt <= bit_cnt + 9'd1;
            to_cnt  <= '0;
            if (bit_cnt[3:0] == 4'hF) acc <= acc_fold;
            if (bit_cnt == 9'd287) state <= CHECK;
          end else if (to_cnt == TO_LAST) begin
            state <= HUNT;
            if (timeouts != 8'hFF) timeouts <= timeouts + 8'd1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        CHECK: begin
          // A bit_valid strobe that arrives in this cycle is dropped.
          state <= HUNT;
          if (sum_ok) begin
            deliver <= port_ok;
          end else if (crc_errors != 8'hFF) begin
            crc_errors <= crc_errors + 8'd1;
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
// Self-checking bench for packet_receiver. Packets are built from their
// fields. The checksum and the delivery decision come from a plain-arithmetic
// model of the packet format, and every readyout pulse is recorded by a
// monitor.
module tb_packet_receiver;

  localparam logic [31:0] SYNC = 32'hA5A5_F00D;
`ifdef PORT_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         bit_in;
  logic         bit_valid;
  logic         readyout;
  logic [31:0]  SEQout;
  logic [31:0]  ACKout;
  logic [8:0]   flagsout;
  logic [15:0]  windowout;
  logic [127:0] message;
  logic         busy;
  logic [7:0]   crc_errors;
  logic [7:0]   timeouts;

  packet_receiver dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .readyout(readyout), .SEQout(SEQout), .ACKout(ACKout),
    .flagsout(flagsout), .windowout(windowout), .message(message),
    .busy(busy), .crc_errors(crc_errors), .timeouts(timeouts)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]  seq;
    logic [31:0]  ack;
    logic [8:0]   flags;
    logic [15:0]  window;
    logic [15:0]  dst;
    logic [127:0] msg;
  } pkt_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected state of the DUT.
  logic [31:0]  exp_seq, exp_ack;
  logic [8:0]   exp_flags;
  logic [15:0]  exp_win;
  logic [127:0] exp_msg;
  int           exp_crc, exp_to;
  int           exp_cyc_q[$];
  logic [31:0]  exp_seq_q[$];

  // Observed readyout pulses.
  int           rdy_cyc_q[$];
  logic [31:0]  rdy_seq_q[$];
  int           consec = 0;
  logic         prev_rdy = 1'b0;
  int           last_cyc;

  always @(negedge clk) begin
    if (readyout === 1'b1) begin
      rdy_cyc_q.push_back(cyc);
      rdy_seq_q.push_back(SEQout);
      if (prev_rdy) consec++;
    end
    prev_rdy = (readyout === 1'b1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fold(input longint s);
    longint t = s;
    while ((t >> 16) != 0) t = (t & 64'hFFFF) + (t >> 16);
    return t[15:0];
  endfunction

  function automatic logic [15:0] bits_sum(input logic [287:0] b);
    longint s = 0;
    for (int k = 0; k < 18; k++) s += longint'(b[287 - 16*k -: 16]);
    return fold(s);
  endfunction

  function automatic logic [287:0] build(input pkt_t p);
    logic [31:0] w [9];
    longint      s = 0;
    logic [15:0] cks;
    w[0] = {16'd1234, p.dst};
    w[1] = p.seq;
    w[2] = p.ack;
    w[3] = {4'd5, 3'd0, p.flags, p.window};
    w[4] = 32'd0;
    w[5] = p.msg[127:96];
    w[6] = p.msg[95:64];
    w[7] = p.msg[63:32];
    w[8] = p.msg[31:0];
    for (int i = 0; i < 9; i++) s += longint'(w[i][31:16]) + longint'(w[i][15:0]);
    cks  = ~fold(s);
    w[4] = {cks, 16'd0};
    return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8]};
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.seq    = $urandom;
    p.ack    = $urandom;
    p.flags  = 9'($urandom);
    p.window = 16'($urandom);
    p.dst    = 16'd80;
    p.msg    = {$urandom, $urandom, $urandom, $urandom};
    return p;
  endfunction

  // The caller is at a negedge. gap <= 0 means a random 2..4 cycles per bit.
  task automatic send_bit(input logic b, input int gap);
    int g;
    g = (gap > 0) ? gap : int'($urandom_range(2, 4));
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    last_cyc  = cyc;
    repeat (g - 1) @(negedge clk);
  endtask

  task automatic send_bits(input logic [287:0] b, input int n, input int gap);
    for (int i = 0; i < n; i++) send_bit(b[287 - i], gap);
  endtask

  task automatic send_sync(input int gap);
    logic [31:0] s;
    s = SYNC;
    for (int i = 31; i >= 0; i--) send_bit(s[i], gap);
  endtask

  // Reference model: decides the outcome of a complete packet.
  task automatic model(input pkt_t p, input logic [287:0] b, input int end_cyc);
    bit good, deliver;
    good    = (bits_sum(b) == 16'hFFFF);
    deliver = good && (!FILTER || p.dst == 16'd80);
    if (deliver) begin
      exp_seq = p.seq; exp_ack = p.ack; exp_flags = p.flags;
      exp_win = p.window; exp_msg = p.msg;
      exp_cyc_q.push_back(end_cyc + 2);
      exp_seq_q.push_back(p.seq);
    end else if (!good && exp_crc < 255) begin
      exp_crc++;
    end
  endtask

  task automatic send_packet(input pkt_t p, input logic [287:0] b, input int gap);
    send_sync(gap);
    send_bits(b, 288, gap);
    model(p, b, last_cyc);
  endtask

  task automatic verify(input string tag);
    int n;
    repeat (8) @(negedge clk);
    check({tag, ".n_ready"}, rdy_cyc_q.size(), exp_cyc_q.size());
    n = (rdy_cyc_q.size() < exp_cyc_q.size()) ? rdy_cyc_q.size() : exp_cyc_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.ready_cycle%0d", tag, i), rdy_cyc_q[i], exp_cyc_q[i]);
      check($sformatf("%s.seq_at_ready%0d", tag, i), rdy_seq_q[i], exp_seq_q[i]);
    end
    check({tag, ".SEQout"},     SEQout,     exp_seq);
    check({tag, ".ACKout"},     ACKout,     exp_ack);
    check({tag, ".flagsout"},   flagsout,   exp_flags);
    check({tag, ".windowout"},  windowout,  exp_win);
    check({tag, ".message"},    message,    exp_msg);
    check({tag, ".crc_errors"}, crc_errors, exp_crc);
    check({tag, ".timeouts"},   timeouts,   exp_to);
    check({tag, ".busy"},       busy,       1'b0);
    rdy_cyc_q.delete(); rdy_seq_q.delete();
    exp_cyc_q.delete(); exp_seq_q.delete();
  endtask

  task automatic clear_model();
    exp_seq = '0; exp_ack = '0; exp_flags = '0; exp_win = '0; exp_msg = '0;
    exp_crc = 0; exp_to = 0;
  endtask

  initial begin
    pkt_t         p, q;
    logic [287:0] b, c;

    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    check("reset.readyout", readyout, 1'b0);
    check("reset.busy", busy, 1'b0);
    check("reset.SEQout", SEQout, 32'd0);
    check("reset.message", message, 128'd0);
    check("reset.crc_errors", crc_errors, 8'd0);
    check("reset.timeouts", timeouts, 8'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Known-good packet, with one bit every 4 clocks.
    p.seq = 32'd5; p.ack = 32'd3; p.flags = 9'h012; p.window = 16'd3;
    p.dst = 16'd80; p.msg = "HELLO WORLD     ";
    b = build(p);
    send_packet(p, b, 4);
    verify("hello");

    // The same packet with one payload bit flipped.
    c = b ^ (288'd1 << 50);
    send_packet(p, c, 4);
    verify("corrupt");

    // Stall after 100 bits, then a normal packet.
    q = rand_pkt();
    send_sync(3);
    send_bits(build(q), 100, 3);
    check("timeout.busy_recv", busy, 1'b1);
    repeat (64990) @(negedge clk);
    check("timeout.busy_before", busy, 1'b1);
    repeat (20) @(negedge clk);
    check("timeout.busy_after", busy, 1'b0);
    exp_to++;
    q = rand_pkt();
    send_packet(q, build(q), 0);
    verify("timeout");

    // Sync word inside the payload, then a second packet sent back to back.
    p = rand_pkt(); p.seq = 32'd5; p.msg[127:96] = SYNC;
    q = rand_pkt(); q.seq = 32'd6;
    send_packet(p, build(p), 3);
    send_packet(q, build(q), 2);
    verify("b2b");

    // Reset asserted at bit 150 of a packet.
    p = rand_pkt();
    b = build(p);
    send_sync(4);
    send_bits(b, 150, 4);
    reset = 1'b1;
    #1;
    check("midreset.busy", busy, 1'b0);
    check("midreset.SEQout", SEQout, 32'd0);
    check("midreset.ACKout", ACKout, 32'd0);
    check("midreset.message", message, 128'd0);
    check("midreset.crc_errors", crc_errors, 8'd0);
    check("midreset.timeouts", timeouts, 8'd0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    send_bits(b << 150, 138, 4);
    verify("midreset");

    // Destination port 81, then port 80.
    p = rand_pkt(); p.dst = 16'd81;
    q = rand_pkt(); q.dst = 16'd80;
    send_packet(p, build(p), 0);
    send_packet(q, build(q), 0);
    verify("portfilter");

    // Random packets, some of them corrupted.
    for (int i = 0; i < 4; i++) begin
      p = rand_pkt();
      if ($urandom_range(0, 1) == 1) p.dst = 16'd81;
      b = build(p);
      if ($urandom_range(0, 3) == 0) b = b ^ (288'd1 << $urandom_range(0, 287));
      send_packet(p, b, 0);
      verify($sformatf("rand%0d", i));
    end

    check("no_consecutive_ready", consec, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_receiver.md
Name: packet_receiver

Overview:
- Receive side of the laser TCP link; the counterpart of the packet generator.
- Hunts a demodulated serial bit stream for a sync word, then deserialises one 288-bit (9×32) packet MSB-first.
- Verifies the 16-bit ones'-complement checksum and presents SEQ/ACK/flags/window/message to the main FSM with a one-cycle ready pulse.
- Replaces the switch-driven incoming stubs in the top level.

Parameters:
- SYNC_WORD, 32'hA5A5_F00D: preamble preceding every packet, MSB first.
- TIMEOUT, 65000: max clk cycles between bit_valid strobes while receiving (1 ms at 65 MHz).
- LOCAL_PORT, 16'd80: our TCP port; used only with PORT_FILTER_EN.

Ports:
- clk  input  1  system clock (65 MHz)
- reset  input  1  asynchronous, active-high
- bit_in  input  1  received data bit, valid when bit_valid=1
- bit_valid  input  1  one-cycle strobe per received bit
- readyout  output  1  one-cycle pulse: new good packet on outputs
- SEQout  output  32  sequence number (word1)
- ACKout  output  32  acknowledgment number (word2)
- flagsout  output  9  TCP flags (word3[24:16])
- windowout  output  16  window (word3[15:0])
- message  output  128  16-character payload (words5–8, word5 = leftmost chars)
- busy  output  1  high in RECV/CHECK
- crc_errors  output  8  saturating count of checksum failures
- timeouts  output  8  saturating count of aborted receptions

Behaviour:
- Packet layout after sync:
  - w0 = {srcport, dstport}
  - w1 = seq
  - w2 = ack
  - w3 = {offset[3:0], rsvd[2:0], flags[8:0], window[15:0]}
  - w4 = {checksum, urgent}
  - w5–w8 = message
- Reset (async): state=HUNT; all outputs 0; sync shifter, bit counter, checksum accumulator, timeout counter cleared.
- HUNT:
  - Each bit_valid shifts bit_in into a 32-bit shifter.
  - When the shifter equals SYNC_WORD on a shift edge, go to RECV with bit count 0 and accumulator 0.
  - Shifter is cleared on the transition.
- RECV:
  - Each bit_valid shifts into the 288-bit packet register and increments the 9-bit bit count.
  - Every 16th bit, the completed halfword is added to a 17-bit accumulator, and the carry is folded back immediately (end-around carry).
  - When bit count reaches 288, go to CHECK.
  - Timeout counter resets on each bit_valid. If it reaches TIMEOUT, go to HUNT, increment timeouts (saturate at 255); outputs are unchanged.
- CHECK (exactly one cycle):
  - Good if the folded sum of all 18 halfwords, checksum field included, equals 16'hFFFF.
  - Good: register w1/w2/flags/window/message onto the outputs and assert readyout for the next cycle.
  - Bad: increment crc_errors (saturate), outputs unchanged.
  - Always return to HUNT.
- Latency: readyout and the new output values appear on the 2nd rising edge after the edge that sampled bit 288.
- Outputs hold their last good packet until the next good packet arrives; readyout is never high for 2 consecutive cycles.
- bit_valid during CHECK is ignored (dropped).
- Sync word appearing inside a payload during RECV has no effect: no re-sync mid-packet.
- Back-to-back packets: the sync of packet N+1 may begin on the first bit_valid after CHECK.
- Reset asserted mid-RECV: immediate return to HUNT; partial data discarded; counters cleared.
- busy = (state != HUNT).

Optional Feature:
- Macro: PORT_FILTER_EN.
- Defined: in CHECK, a good-checksum packet whose dstport (w0[15:0]) != LOCAL_PORT is discarded silently. No readyout, outputs unchanged, no counter change.
- Undefined: dstport is ignored; every good-checksum packet is delivered; the LOCAL_PORT parameter is unused.

Test Plan:
- Sync + valid packet (seq=5, ack=3, flags=9'h012 SYN|ACK, window=3, message "HELLO WORLD     ", correct checksum), bit_valid every 4 clks -> single readyout pulse 2 clks after last bit; SEQout=5, ACKout=3, flagsout=9'h012, windowout=3, message matches; crc_errors=0.
- Same packet with one payload bit flipped -> no readyout; outputs keep prior values; crc_errors=1.
- Sync, then stop bit_valid after 100 bits for 65000 clks -> back to HUNT (busy=0); timeouts=1; following valid packet accepted normally.
- Payload containing 32'hA5A5F00D, followed immediately by a second valid packet (seq=6) -> two readyout pulses; SEQout=5 then 6.
- Reset asserted for 1 clk at bit 150 of a packet -> busy=0 and all outputs 0 in the same cycle; the remaining 138 bits produce no readyout.
- PORT_FILTER_EN defined, LOCAL_PORT=80: packets with dstport=81 then dstport=80 -> only the second produces readyout.
